decode_ctrl_pipe: RTL and testbench
===================================

Name: decode_ctrl_pipe

Overview:
- Next-generation decode control unit for the 5-stage core.
- Decodes the IF/ID opcode into the 9-bit control bundle and registers it into the ID/EX stage, together with rt and a valid bit.
- Generates the front-end stall for two cases:
  - load-use hazards;
  - a parametrised multi-cycle MUL that occupies EX.
- Inserts bubbles on flush and illegal opcodes.
- Sits between the IF/ID register and the EX stage. It replaces the purely combinational opcode decode.

Parameters:
- OPCODE_W, 6, opcode width.
- REG_W, 5, register-index width.
- MUL_LATENCY, 3, cycles a MUL occupies EX (≥1; 1 = no MUL stall).
- ZERO_REG, 1, when 1, register index 0 never causes a hazard.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  IF/ID holds a real instruction.
- opcode  in  OPCODE_W  IF/ID instruction[31:26].
- rs  in  REG_W  IF/ID source register 1.
- rt  in  REG_W  IF/ID source/destination register 2.
- flush  in  1  branch taken / jump resolved; kills the instruction entering ID/EX.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- id_ex_valid  out  1  ID/EX holds a live instruction.
- id_ex_ctrl  out  9  registered bundle {word,jump,regWrite,aluSrc,memWrite,memToReg,memRead,branch,regDst}, where bit0 = regDst.
- id_ex_rt  out  REG_W  registered rt.
- mul_busy  out  1  MUL in ID/EX still executing.
- illegal_q  out  1  one-cycle pulse: an unknown opcode was squashed.

Behaviour:
- Only clk is used; reset is synchronous, active-high.
- Reset values: id_ex_valid=0, id_ex_ctrl=0, id_ex_rt=0, mul counter=0, illegal_q=0. Consequently stall=0 and mul_busy=0.
- Decode (combinational), ctrl values:
  - 0x00 ADD = 0x041
  - 0x01 SUB = 0x041
  - 0x02 MUL = 0x041
  - 0x10 LDB = 0x06C
  - 0x11 LDW = 0x16C
  - 0x12 STB = 0x030
  - 0x13 STW = 0x130
  - 0x30 BEQ = 0x002
  - 0x31 JUMP = 0x080
  - any other opcode = 0x000, and it is flagged illegal.
- uses_rt is true for R-type (0x00-0x02), STB, STW and BEQ.
- Load-use hazard (lu):
  - Condition: id_ex_valid & id_ex_ctrl.memRead & instr_valid & (id_ex_rt==rs | (uses_rt & id_ex_rt==rt)).
  - When ZERO_REG=1 and id_ex_rt==0, lu is suppressed.
- MUL counter:
  - Width is clog2(MUL_LATENCY+1).
  - Loaded with MUL_LATENCY-1 when a MUL is written into ID/EX.
  - Decrements each cycle while nonzero.
  - mul_busy = (counter != 0).
- stall = ~flush & (mul_busy | lu).
- ID/EX update priority, evaluated each clk edge:
  1. reset: state cleared.
  2. flush: bubble written (valid=0, ctrl=0, rt=0) and counter cleared. Flush overrides both MUL and lu stall, because the flushed instruction is younger.
  3. mul_busy: ID/EX holds its contents and the counter decrements.
  4. lu: bubble inserted while IF/ID is held upstream. The stalled instruction issues on the next cycle.
  5. instr_valid=0: bubble.
  6. Illegal opcode: bubble, and illegal_q=1 for that cycle.
  7. Otherwise: load valid=1, ctrl=decoded value, rt=rt.
- illegal_q is 0 on every other cycle.
- Latency: decode to ID/EX is 1 cycle. MUL throughput is one per MUL_LATENCY cycles. Load-use costs exactly one bubble.
- Back-to-back MULs: the second MUL is stalled until the counter reaches 0, then issues. It reloads the counter the same cycle it issues.
- mul_busy and lu in the same cycle: hold has priority. When mul_busy drops, lu is re-evaluated against the held ID/EX contents.
- Reset asserted mid-MUL: the counter is cleared and stall drops in the same cycle.

Test Plan:
1. Reset: hold reset 2 cycles with opcode=0x11, instr_valid=1 → id_ex_valid=0, id_ex_ctrl=0x000, stall=0, mul_busy=0, illegal_q=0.
2. Load-use: issue LDW (rt=5), then ADD (rs=5) → stall=1 for one cycle, ID/EX gets a bubble, next cycle id_ex_ctrl=0x041 with valid=1. Same sequence with LDW rt=0 (ZERO_REG=1) → no stall.
3. MUL with MUL_LATENCY=3: MUL then SUB → mul_busy and stall high 2 cycles, ID/EX holds 0x041, SUB enters on the 3rd cycle. Also run with MUL_LATENCY=1 → no stall.
4. Flush while mul_busy: MUL enters ID/EX, flush next cycle → following edge: id_ex_valid=0, ctrl=0, mul_busy=0, stall=0.
5. Illegal opcode 0x3F → id_ex_valid=0, id_ex_ctrl=0, illegal_q=1 for exactly one cycle. Then BEQ → id_ex_ctrl=0x002.
6. Store-after-load: LDW rt=7, then STB with rt=7 → stall 1 cycle, then id_ex_ctrl=0x030. JUMP after LDW rt=7 (rs=0, rt=0) → no stall, id_ex_ctrl=0x080.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: opcode decode into the ID/EX control register with load-use and multi-cycle MUL stalls.
module decode_ctrl_pipe #(
  parameter int OPCODE_W = 6,
  parameter int REG_W = 5,
  parameter int MUL_LATENCY = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic                flush,
  output logic                stall,
  output logic                id_ex_valid,
  output logic [8:0]          id_ex_ctrl,
  output logic [REG_W-1:0]    id_ex_rt,
  output logic                mul_busy,
  output logic                illegal_q
);
  localparam int CW = $clog2(MUL_LATENCY + 1);
  logic [8:0] ctrl;
  logic legal, uses_rt, is_mul, lu;
  logic [CW-1:0] cnt;
  always_comb begin
    ctrl = '0;
    legal = 1'b1;
    uses_rt = 1'b0;
    case (opcode)
      OPCODE_W'(6'h00), OPCODE_W'(6'h01), OPCODE_W'(6'h02): begin ctrl = 9'h041; uses_rt = 1'b1; end
      OPCODE_W'(6'h10): ctrl = 9'h06C;
      OPCODE_W'(6'h11): ctrl = 9'h16C;
      OPCODE_W'(6'h12): begin ctrl = 9'h030; uses_rt = 1'b1; end
      OPCODE_W'(6'h13): begin ctrl = 9'h130; uses_rt = 1'b1; end
      OPCODE_W'(6'h30): begin ctrl = 9'h002; uses_rt = 1'b1; end
      OPCODE_W'(6'h31): ctrl = 9'h080;
      default: legal = 1'b0;
    endcase
  end
  assign is_mul = opcode == OPCODE_W'(6'h02);
  // bit 2 of the bundle is memRead
  assign lu = id_ex_valid & id_ex_ctrl[2] & instr_valid
            & (id_ex_rt == rs | (uses_rt & id_ex_rt == rt))
            & (ZERO_REG == 0 || id_ex_rt != '0);
  assign mul_busy = cnt != '0;
  assign stall = ~flush & (mul_busy | lu);
  always_ff @(posedge clk) begin
    if (reset | flush) begin
      id_ex_valid <= 1'b0;
      id_ex_ctrl <= '0;
      id_ex_rt <= '0;
      cnt <= '0;
      illegal_q <= 1'b0;
    end else if (mul_busy) begin
      cnt <= cnt - CW'(1);
      illegal_q <= 1'b0;
    end else if (lu | ~instr_valid | ~legal) begin
      id_ex_valid <= 1'b0;
      id_ex_ctrl <= '0;
      id_ex_rt <= '0;
      illegal_q <= instr_valid & ~lu & ~legal;
    end else begin
      id_ex_valid <= 1'b1;
      id_ex_ctrl <= ctrl;
      id_ex_rt <= rt;
      cnt <= is_mul ? CW'(MUL_LATENCY - 1) : '0;
      illegal_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: directed and random checks of two decode_ctrl_pipe instances (MUL_LATENCY 3 and 1) against a behavioural model.
module tb_decode_ctrl_pipe;
  logic clk = 1'b0, reset = 1'b1, iv = 1'b0, flush = 1'b0;
  logic [5:0] op = '0;
  logic [4:0] rs = '0, rt = '0;
  logic [1:0] st, vb, mb, iq;
  logic [8:0] ct [2];
  logic [4:0] rr [2];
  int checks = 0, errors = 0;
  bit chk_en = 0;
  bit mv [2];
  logic [8:0] mc [2];
  logic [4:0] mr [2];
  int ml [2];
  bit mi [2];
  int lat [2] = '{3, 1};
  always #5 clk = ~clk;
  decode_ctrl_pipe dut (.clk(clk), .reset(reset), .instr_valid(iv), .opcode(op), .rs(rs), .rt(rt),
    .flush(flush), .stall(st[0]), .id_ex_valid(vb[0]), .id_ex_ctrl(ct[0]), .id_ex_rt(rr[0]),
    .mul_busy(mb[0]), .illegal_q(iq[0]));
  decode_ctrl_pipe #(.MUL_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .instr_valid(iv), .opcode(op),
    .rs(rs), .rt(rt), .flush(flush), .stall(st[1]), .id_ex_valid(vb[1]), .id_ex_ctrl(ct[1]),
    .id_ex_rt(rr[1]), .mul_busy(mb[1]), .illegal_q(iq[1]));
  function automatic logic [8:0] dctl(logic [5:0] o);
    case (o)
      6'h00, 6'h01, 6'h02: return 9'h041;
      6'h10: return 9'h06C;
      6'h11: return 9'h16C;
      6'h12: return 9'h030;
      6'h13: return 9'h130;
      6'h30: return 9'h002;
      6'h31: return 9'h080;
      default: return 9'h000;
    endcase
  endfunction
  function automatic bit legal(logic [5:0] o);
    return o inside {6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12, 6'h13, 6'h30, 6'h31};
  endfunction
  function automatic bit urt(logic [5:0] o);
    return o <= 6'h02 || o == 6'h12 || o == 6'h13 || o == 6'h30;
  endfunction
  function automatic bit is_load(logic [8:0] c);
    return c == 9'h06C || c == 9'h16C;
  endfunction
  function automatic bit m_lu(int k);
    return mv[k] && is_load(mc[k]) && iv && mr[k] != 0 && (mr[k] == rs || (urt(op) && mr[k] == rt));
  endfunction
  task automatic cmp(string n, int k, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", n, k, a, e, $time);
    end
  endtask
  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      cmp("mul_busy", k, 32'(mb[k]), 32'(ml[k] > 0));
      cmp("stall", k, 32'(st[k]), 32'(!flush && (ml[k] > 0 || m_lu(k))));
      cmp("valid", k, 32'(vb[k]), 32'(mv[k]));
      cmp("ctrl", k, 32'(ct[k]), 32'(mc[k]));
      cmp("rt", k, 32'(rr[k]), 32'(mr[k]));
      cmp("illegal_q", k, 32'(iq[k]), 32'(mi[k]));
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit lu;
      lu = m_lu(k);
      mi[k] = 0;
      if (reset || flush) begin
        mv[k] = 0; mc[k] = '0; mr[k] = '0; ml[k] = 0;
      end else if (ml[k] > 0) begin
        ml[k]--;
      end else if (lu || !iv || !legal(op)) begin
        mv[k] = 0; mc[k] = '0; mr[k] = '0;
        mi[k] = iv && !lu && !legal(op);
      end else begin
        mv[k] = 1; mc[k] = dctl(op); mr[k] = rt;
        ml[k] = (op == 6'h02) ? lat[k] - 1 : 0;
      end
    end
  endtask
  task automatic drive(bit v, logic [5:0] o, logic [4:0] s, logic [4:0] t, bit f);
    iv = v; op = o; rs = s; rt = t; flush = f;
  endtask
  task automatic tick();
    @(negedge clk);
    if (chk_en) model_check();
    model_step();
    @(posedge clk);
    #1;
    chk_en = 1;
  endtask
  initial begin
    drive(1, 6'h11, 5'd1, 5'd2, 0);
    reset = 1;
    tick(); tick();
    cmp("rst_valid", 0, 32'(vb[0]), 0);
    cmp("rst_ctrl", 0, 32'(ct[0]), 0);
    cmp("rst_stall", 0, 32'(st[0]), 0);
    cmp("rst_busy", 0, 32'(mb[0]), 0);
    cmp("rst_illegal", 0, 32'(iq[0]), 0);
    reset = 0;
    drive(1, 6'h11, 5'd1, 5'd5, 0); tick();
    drive(1, 6'h00, 5'd5, 5'd2, 0); #1;
    cmp("lu_stall", 0, 32'(st[0]), 1);
    tick();
    cmp("lu_bubble", 0, 32'(vb[0]), 0);
    cmp("lu_release", 0, 32'(st[0]), 0);
    tick();
    cmp("lu_issue_ctrl", 0, 32'(ct[0]), 32'h041);
    cmp("lu_issue_valid", 0, 32'(vb[0]), 1);
    drive(1, 6'h11, 5'd3, 5'd0, 0); tick();
    drive(1, 6'h00, 5'd0, 5'd4, 0); #1;
    cmp("zero_reg_stall", 0, 32'(st[0]), 0);
    tick();
    cmp("zero_reg_ctrl", 0, 32'(ct[0]), 32'h041);
    drive(1, 6'h02, 5'd1, 5'd2, 0); tick();
    cmp("mul_busy3", 0, 32'(mb[0]), 1);
    cmp("mul_busy1", 1, 32'(mb[1]), 0);
    drive(1, 6'h01, 5'd3, 5'd4, 0); #1;
    cmp("mul_stall3", 0, 32'(st[0]), 1);
    cmp("mul_stall1", 1, 32'(st[1]), 0);
    tick();
    cmp("mul_hold_rt", 0, 32'(rr[0]), 2);
    cmp("mul_hold_stall", 0, 32'(st[0]), 1);
    cmp("sub_lat1_rt", 1, 32'(rr[1]), 4);
    tick();
    cmp("mul_done", 0, 32'(mb[0]), 0);
    cmp("mul_done_ctrl", 0, 32'(ct[0]), 32'h041);
    tick();
    cmp("sub_issue_rt", 0, 32'(rr[0]), 4);
    drive(1, 6'h02, 5'd1, 5'd6, 0); tick();
    drive(1, 6'h01, 5'd1, 5'd2, 1); #1;
    cmp("flush_stall", 0, 32'(st[0]), 0);
    tick();
    drive(0, 6'h00, 5'd0, 5'd0, 0); #1;
    cmp("flush_valid", 0, 32'(vb[0]), 0);
    cmp("flush_ctrl", 0, 32'(ct[0]), 0);
    cmp("flush_busy", 0, 32'(mb[0]), 0);
    cmp("flush_stall2", 0, 32'(st[0]), 0);
    drive(1, 6'h3F, 5'd1, 5'd2, 0); tick();
    cmp("ill_valid", 0, 32'(vb[0]), 0);
    cmp("ill_ctrl", 0, 32'(ct[0]), 0);
    cmp("ill_pulse", 0, 32'(iq[0]), 1);
    drive(1, 6'h30, 5'd1, 5'd2, 0); tick();
    cmp("ill_clear", 0, 32'(iq[0]), 0);
    cmp("beq_ctrl", 0, 32'(ct[0]), 32'h002);
    drive(1, 6'h11, 5'd1, 5'd7, 0); tick();
    drive(1, 6'h12, 5'd2, 5'd7, 0); #1;
    cmp("stb_stall", 0, 32'(st[0]), 1);
    tick(); tick();
    cmp("stb_ctrl", 0, 32'(ct[0]), 32'h030);
    drive(1, 6'h11, 5'd1, 5'd7, 0); tick();
    drive(1, 6'h31, 5'd0, 5'd0, 0); #1;
    cmp("jump_stall", 0, 32'(st[0]), 0);
    tick();
    cmp("jump_ctrl", 0, 32'(ct[0]), 32'h080);
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] ops [9];
      ops = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12, 6'h13, 6'h30, 6'h31};
      reset = $urandom_range(0, 99) == 0;
      drive($urandom_range(0, 99) < 85,
            ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
